// File: rtl/data_mem_pkg.sv
// Shared definitions for the data memory pipe: RV32 load/store funct3 codes,
// FSM state encoding, latency counter width and the LATENCY range check.
package data_mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int LAT_MIN = 1;
    localparam int LAT_MAX = 4;
    localparam int CNT_W   = 2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    function automatic bit latency_ok(input int lat);
        return (lat >= LAT_MIN) && (lat <= LAT_MAX);
    endfunction

    // An out-of-range LATENCY falls back to the minimum rather than
    // producing a counter that cannot hold the reload value.
    function automatic int latency_eff(input int lat);
        return latency_ok(lat) ? lat : LAT_MIN;
    endfunction

endpackage

// File: rtl/data_mem_align.sv
// Combinational access decode: size/sign from funct3, byte-lane enables,
// load extension and error flags (illegal funct3, misaligned, out of range).
// Macro DATA_MEM_MISALIGN_EN: when defined, misaligned halfword/word accesses
// are legal and handled byte-wise; otherwise they are reported as errors.
module data_mem_align import data_mem_pkg::*; #(
    parameter int DEPTH_BYTES = 4096,
    parameter int ADDR_W      = 32
) (
    input  logic              we,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       rbytes,
    output logic [31:0]       rdata,
    output logic [3:0]        wbe,
    output logic              err
);

    logic [2:0]    size;
    logic          sign;
    logic          bad_f3;
    logic          misalign;
    logic          out_of_range;
    logic [ADDR_W:0] last_addr;
    logic [3:0]    mask;

    // Size and signedness decode; unsigned codes are only legal for loads.
    always_comb begin
        size   = 3'd1;
        sign   = 1'b0;
        bad_f3 = 1'b0;
        case (funct3)
            F3_B:    begin size = 3'd1; sign = 1'b1; end
            F3_H:    begin size = 3'd2; sign = 1'b1; end
            F3_W:    begin size = 3'd4; end
            F3_BU:   begin size = 3'd1; bad_f3 = we; end
            F3_HU:   begin size = 3'd2; bad_f3 = we; end
            default: begin bad_f3 = 1'b1; end
        endcase
    end

`ifdef DATA_MEM_MISALIGN_EN
    assign misalign = 1'b0;
`else
    assign misalign = ((size == 3'd2) && addr[0]) ||
                      ((size == 3'd4) && (addr[1:0] != 2'b00));
`endif

    // Last byte touched, computed one bit wider so it cannot wrap.
    assign last_addr    = {1'b0, addr} + (ADDR_W+1)'(size - 3'd1);
    assign out_of_range = last_addr > (ADDR_W+1)'(DEPTH_BYTES - 1);
    assign err          = bad_f3 | misalign | out_of_range;

    // Byte lanes relative to addr, plus load extension gated to zero on
    // stores and errors.
    always_comb begin
        mask  = 4'b1111;
        rdata = rbytes;
        case (size)
            3'd1: begin
                mask  = 4'b0001;
                rdata = {{24{sign & rbytes[7]}}, rbytes[7:0]};
            end
            3'd2: begin
                mask  = 4'b0011;
                rdata = {{16{sign & rbytes[15]}}, rbytes[15:0]};
            end
            default: begin
                mask  = 4'b1111;
                rdata = rbytes;
            end
        endcase
        if (we || err) rdata = 32'h0;
        wbe = (we && !err) ? mask : 4'b0000;
    end

endmodule

// File: rtl/data_mem_pipe.sv
// Byte-addressed data memory with a single-outstanding request/response
// handshake and fixed LATENCY. Stores commit and loads sample at accept.
// Macro DATA_MEM_MISALIGN_EN enables byte-wise misaligned accesses
// (see data_mem_align).
//
// state  | meaning
// -------+-----------------------------------------------
// S_IDLE | ready for a request (req_ready=1)
// S_WAIT | request accepted, counting down latency
// S_RESP | response held on rsp_* until rsp_ready
module data_mem_pipe import data_mem_pkg::*; #(
    parameter int DEPTH_BYTES = 4096,
    parameter int ADDR_W      = 32,
    parameter int LATENCY     = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err
);

    localparam int LAT   = latency_eff(LATENCY);
    localparam int IDX_W = $clog2(DEPTH_BYTES);

    logic [7:0]       mem [DEPTH_BYTES];
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             accept;
    logic [IDX_W-1:0] base;
    logic [31:0]      rbytes;
    logic [31:0]      a_rdata;
    logic [3:0]       a_wbe;
    logic             a_err;
    logic [31:0]      rdata_q;
    logic             err_q;

    assign req_ready = (state_q == S_IDLE);
    assign rsp_valid = (state_q == S_RESP);
    assign accept    = req_valid && req_ready;
    assign base      = req_addr[IDX_W-1:0];
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

    // Gather the four bytes starting at the request address; wrapped lanes
    // only matter for accesses already flagged out of range.
    always_comb begin
        rbytes = 32'h0;
        for (int i = 0; i < 4; i++) begin
            rbytes[8*i +: 8] = mem[base + IDX_W'(i)];
        end
    end

    data_mem_align #(
        .DEPTH_BYTES (DEPTH_BYTES),
        .ADDR_W      (ADDR_W)
    ) u_align (
        .we     (req_we),
        .funct3 (req_funct3),
        .addr   (req_addr),
        .rbytes (rbytes),
        .rdata  (a_rdata),
        .wbe    (a_wbe),
        .err    (a_err)
    );

    // Store commit at the accept edge; array is deliberately not reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int i = 0; i < 4; i++) begin
                if (a_wbe[i]) mem[base + IDX_W'(i)] <= req_wdata[8*i +: 8];
            end
        end
    end

    // State and latency counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic; RESP is entered as the counter reaches zero.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (LAT == 1) begin
                        state_d = S_RESP;
                        cnt_d   = '0;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = CNT_W'(LAT - 1);
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = S_RESP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_RESP: begin
                if (rsp_ready) state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Response payload captured at accept and held through RESP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else if (accept) begin
            rdata_q <= a_rdata;
            err_q   <= a_err;
        end
    end

endmodule

// File: tb/tb_data_mem_pipe.sv
// Directed bench for data_mem_pipe: one LATENCY=1 and one LATENCY=3 instance.
module tb_data_mem_pipe;

    localparam int DEPTH = 4096;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        v1, v3;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_ready;

    logic        rr1, rv1, re1;
    logic [31:0] rd1;
    logic        rr3, rv3, re3;
    logic [31:0] rd3;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    data_mem_pipe #(.DEPTH_BYTES(DEPTH), .ADDR_W(32), .LATENCY(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .req_valid(v1), .req_ready(rr1),
        .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rv1), .rsp_ready(rsp_ready),
        .rsp_rdata(rd1), .rsp_err(re1)
    );

    data_mem_pipe #(.DEPTH_BYTES(DEPTH), .ADDR_W(32), .LATENCY(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .req_valid(v3), .req_ready(rr3),
        .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rv3), .rsp_ready(rsp_ready),
        .rsp_rdata(rd3), .rsp_err(re3)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One request on the selected instance with rsp_ready high; lat counts
    // the cycle after the accept edge as 1.
    task automatic xact(input int sel, input logic we, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output logic er, output int lat);
        @(negedge clk);
        req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
        if (sel == 1) v1 = 1'b1; else v3 = 1'b1;
        @(posedge clk); #1;
        v1 = 1'b0; v3 = 1'b0;
        lat = 1;
        while (!((sel == 1) ? rv1 : rv3) && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        rd = (sel == 1) ? rd1 : rd3;
        er = (sel == 1) ? re1 : re3;
        @(posedge clk); #1;
    endtask

    task automatic run(input int sel, input logic we, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] exp_rd, input logic exp_err, input string tag);
        logic [31:0] rd;
        logic        er;
        int          lat;
        xact(sel, we, f3, a, wd, rd, er, lat);
        check_eq({tag, "_rd"}, rd, exp_rd);
        check_eq({tag, "_err"}, {31'b0, er}, {31'b0, exp_err});
        check_eq({tag, "_lat"}, lat, sel);
    endtask

    initial begin
        bit seen;
        rst_n = 1'b0; v1 = 1'b0; v3 = 1'b0; req_we = 1'b0;
        req_funct3 = 3'b0; req_addr = 32'h0; req_wdata = 32'h0; rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_ready1", {31'b0, rr1}, 32'd1);
        check_eq("rst_valid1", {31'b0, rv1}, 32'd0);
        check_eq("rst_rdata1", rd1, 32'h0);
        check_eq("rst_err1",   {31'b0, re1}, 32'd0);
        check_eq("rst_ready3", {31'b0, rr3}, 32'd1);
        check_eq("rst_valid3", {31'b0, rv3}, 32'd0);
        @(negedge clk) rst_n = 1'b1;

        // LATENCY=1 instance
        run(1, 1'b1, 3'b010, 32'h10, 32'h12345678, 32'h0,        1'b0, "sw_10");
        run(1, 1'b0, 3'b010, 32'h10, 32'h0,        32'h12345678, 1'b0, "lw_10");
        run(1, 1'b0, 3'b000, 32'h13, 32'h0,        32'h00000012, 1'b0, "lb_13");
        run(1, 1'b1, 3'b000, 32'h20, 32'h00000080, 32'h0,        1'b0, "sb_20");
        run(1, 1'b0, 3'b000, 32'h20, 32'h0,        32'hFFFFFF80, 1'b0, "lb_20");
        run(1, 1'b0, 3'b100, 32'h20, 32'h0,        32'h00000080, 1'b0, "lbu_20");
        run(1, 1'b0, 3'b001, 32'h12, 32'h0,        32'h00001234, 1'b0, "lh_12");
        run(1, 1'b0, 3'b101, 32'h10, 32'h0,        32'h00005678, 1'b0, "lhu_10");
        run(1, 1'b1, 3'b001, 32'h22, 32'h00008001, 32'h0,        1'b0, "sh_22");
        run(1, 1'b0, 3'b001, 32'h22, 32'h0,        32'hFFFF8001, 1'b0, "lh_22");
        run(1, 1'b0, 3'b101, 32'h22, 32'h0,        32'h00008001, 1'b0, "lhu_22");

        // Misaligned accesses
        run(1, 1'b1, 3'b010, 32'h14, 32'h0,        32'h0,        1'b0, "sw_14");
        run(1, 1'b1, 3'b010, 32'h30, 32'h0,        32'h0,        1'b0, "sw_30");
        run(1, 1'b1, 3'b010, 32'h34, 32'h0,        32'h0,        1'b0, "sw_34");
`ifdef DATA_MEM_MISALIGN_EN
        run(1, 1'b0, 3'b010, 32'h11, 32'h0,        32'h00123456, 1'b0, "lw_11");
        run(1, 1'b0, 3'b001, 32'h11, 32'h0,        32'h00003456, 1'b0, "lh_11");
        run(1, 1'b1, 3'b010, 32'h31, 32'hAABBCCDD, 32'h0,        1'b0, "sw_31");
        run(1, 1'b0, 3'b010, 32'h30, 32'h0,        32'hBBCCDD00, 1'b0, "lw_30");
        run(1, 1'b0, 3'b010, 32'h34, 32'h0,        32'h000000AA, 1'b0, "lw_34");
`else
        run(1, 1'b0, 3'b010, 32'h11, 32'h0,        32'h0,        1'b1, "lw_11");
        run(1, 1'b0, 3'b001, 32'h11, 32'h0,        32'h0,        1'b1, "lh_11");
        run(1, 1'b1, 3'b010, 32'h31, 32'hAABBCCDD, 32'h0,        1'b1, "sw_31");
        run(1, 1'b0, 3'b010, 32'h30, 32'h0,        32'h0,        1'b0, "lw_30");
        run(1, 1'b0, 3'b010, 32'h34, 32'h0,        32'h0,        1'b0, "lw_34");
`endif
        run(1, 1'b0, 3'b010, 32'h10, 32'h0,        32'h12345678, 1'b0, "lw_10_again");

        // Range boundary and illegal funct3
        run(1, 1'b1, 3'b001, DEPTH-2, 32'h0,        32'h0, 1'b0, "sh_top");
        run(1, 1'b1, 3'b010, DEPTH-2, 32'hFFFFFFFF, 32'h0, 1'b1, "sw_top");
        run(1, 1'b0, 3'b101, DEPTH-2, 32'h0,        32'h0, 1'b0, "lhu_top");
        run(1, 1'b0, 3'b000, DEPTH-1, 32'h0,        32'h0, 1'b0, "lb_last");
        run(1, 1'b0, 3'b000, DEPTH,   32'h0,        32'h0, 1'b1, "lb_depth");
        run(1, 1'b0, 3'b011, 32'h10,  32'h0,        32'h0, 1'b1, "ld_f3_011");
        run(1, 1'b0, 3'b110, 32'h10,  32'h0,        32'h0, 1'b1, "ld_f3_110");
        run(1, 1'b1, 3'b100, 32'h10,  32'hFFFFFFFF, 32'h0, 1'b1, "st_f3_100");
        run(1, 1'b0, 3'b010, 32'h10,  32'h0, 32'h12345678, 1'b0, "lw_10_kept");

        // LATENCY=3 instance
        run(3, 1'b1, 3'b010, 32'h40, 32'hCAFEF00D, 32'h0,        1'b0, "l3_sw_40");
        run(3, 1'b0, 3'b010, 32'h40, 32'h0,        32'hCAFEF00D, 1'b0, "l3_lw_40");

        // Backpressure: rsp_ready low while response is held
        rsp_ready = 1'b0;
        @(negedge clk);
        req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h40; req_wdata = 32'h0; v3 = 1'b1;
        @(posedge clk); #1;
        v3 = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            check_eq($sformatf("bp_valid_c%0d", c), {31'b0, rv3}, (c >= 3) ? 32'd1 : 32'd0);
            check_eq($sformatf("bp_ready_c%0d", c), {31'b0, rr3}, 32'd0);
            if (c >= 3) check_eq($sformatf("bp_rdata_c%0d", c), rd3, 32'hCAFEF00D);
            @(posedge clk); #1;
        end
        @(negedge clk) rsp_ready = 1'b1;
        @(posedge clk); #1;
        check_eq("bp_valid_done", {31'b0, rv3}, 32'd0);
        check_eq("bp_ready_done", {31'b0, rr3}, 32'd1);

        // Reset during WAIT after a store accept
        @(negedge clk);
        req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h50; req_wdata = 32'h5A5A1234; v3 = 1'b1;
        @(posedge clk); #1;
        v3 = 1'b0;
        check_eq("rw_wait_valid", {31'b0, rv3}, 32'd0);
        #2 rst_n = 1'b0;
        #1;
        check_eq("rw_rst_valid", {31'b0, rv3}, 32'd0);
        check_eq("rw_rst_ready", {31'b0, rr3}, 32'd1);
        check_eq("rw_rst_rdata", rd3, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        seen = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            if (rv3) seen = 1'b1;
        end
        check_eq("rw_no_rsp", {31'b0, seen}, 32'd0);
        run(3, 1'b0, 3'b010, 32'h50, 32'h0, 32'h5A5A1234, 1'b0, "rw_lw_50");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/data_mem_pipe.md
DATA_MEM_PIPE -- requirements
Module: data_mem_pipe

Interface
REQ-001 SHALL have parameter DEPTH_BYTES, default 4096, memory size in bytes (power of two, >=4).
REQ-002 SHALL have parameter ADDR_W, default 32, request address width.
REQ-003 SHALL have parameter LATENCY, default 1, cycles from request accept to response valid (range 1..4).
REQ-004 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port req_valid  input  1  request present.
REQ-007 SHALL have port req_ready  output  1  block can accept a request.
REQ-008 SHALL have port req_we  input  1  1=store, 0=load.
REQ-009 SHALL have port req_funct3  input  3  access size/sign (RV32 load/store funct3 encoding).
REQ-010 SHALL have port req_addr  input  ADDR_W  byte address.
REQ-011 SHALL have port req_wdata  input  32  store data, low bytes used.
REQ-012 SHALL have port rsp_valid  output  1  response present.
REQ-013 SHALL have port rsp_ready  input  1  consumer takes response.
REQ-014 SHALL have port rsp_rdata  output  32  load result, 0 for stores and errors.
REQ-015 SHALL have port rsp_err  output  1  request rejected (misaligned, out-of-range, illegal funct3).

Function
REQ-016 SHALL implement FSM IDLE -> WAIT -> RESP -> IDLE; one request outstanding at most.
REQ-017 req_ready SHALL be 1 exactly in IDLE; accept = req_valid && req_ready at rising edge.
REQ-018 On accept, SHALL go to WAIT with latency counter = LATENCY-1; if LATENCY==1, go directly to RESP.
REQ-019 In WAIT, counter SHALL decrement each cycle; at 0, go to RESP.
REQ-020 rsp_valid SHALL be 1 exactly in RESP, first asserted LATENCY cycles after the accept edge.
REQ-021 RESP SHALL hold rsp_rdata/rsp_err stable until rsp_valid && rsp_ready, then go to IDLE; no new accept in that same cycle.
REQ-022 Store bytes SHALL be committed at the accept edge (SB 1, SH 2, SW 4 bytes, little-endian); load data SHALL be captured at the accept edge.
REQ-023 Load funct3 SHALL decode as: 000 LB sign-extended, 001 LH sign-extended, 010 LW, 100 LBU, 101 LHU; all other load codes SHALL be errors.
REQ-024 Store funct3 SHALL decode as: 000 SB, 001 SH, 010 SW; all other store codes SHALL be errors.
REQ-025 An access with any byte >= DEPTH_BYTES SHALL be an error; no bytes written.
REQ-026 On error, rsp_err=1, rsp_rdata=0, memory SHALL be unchanged, and latency SHALL be identical to a normal access.
REQ-027 A load accepted after a store's response SHALL observe the stored bytes.

Reset
REQ-028 rst_n low SHALL force IDLE, counter 0, rsp_valid 0, rsp_rdata 0, rsp_err 0, req_ready 1 asynchronously.
REQ-029 Reset during WAIT/RESP SHALL drop the pending response; a store already committed at accept SHALL remain committed.
REQ-030 The memory array SHALL NOT be reset; it SHALL be zero-initialised at simulation start.

Configuration
REQ-031 Macro DATA_MEM_MISALIGN_EN: when defined, misaligned LH/LHU/SH (addr[0]=1) and LW/SW (addr[1:0]!=0) SHALL complete byte-wise with normal latency; when undefined, they SHALL be errors per REQ-026.

Structure
REQ-032 Package data_mem_pkg SHALL hold the funct3 constants, the FSM state typedef, and the LATENCY range check.
REQ-033 Sub-module data_mem_align SHALL be combinational: size/sign decode, lane extraction, sign/zero extension, misalign and range error flags.

Verification
REQ-034 LATENCY=1: SW 0x12345678 @0x10, then LW @0x10 -> rsp_valid 1 cycle after each accept, rdata 0x12345678, err 0.
REQ-035 LB @0x13 -> 0x00000012; SB 0x80 @0x20 then LB -> 0xFFFFFF80, LBU -> 0x00000080.
REQ-036 LATENCY=3, rsp_ready held low 5 cycles -> rsp_valid at accept+3, data stable, req_ready 0 until handshake.
REQ-037 LW @0x11 without macro -> err 1, rdata 0, memory untouched; with macro -> 0x??123456-style byte-wise little-endian result.
REQ-038 SW @DEPTH_BYTES-2 -> err 1, no write; funct3 011 load -> err 1.
REQ-039 Assert rst_n low in WAIT after SW accept -> no rsp_valid; subsequent LW returns stored data.
